// File: rtl/gmii_rx_frame.sv
// gmii_rx_frame: GMII receive framer. Strips preamble/SFD, checks the FCS,
// enforces MIN_LEN/MAX_LEN and emits the frame as a byte stream with
// sof/eof markers plus a one-cycle status word at end of frame.
// Optional destination-address filter: define GMII_RX_MAC_FILTER_EN.
module gmii_rx_frame #(
   parameter int unsigned MIN_LEN   = 64,
   parameter int unsigned MAX_LEN   = 1518,
   parameter logic [47:0] LOCAL_MAC = 48'h00_12_34_56_78_9A
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rx_dv,
   input  logic [7:0]  rx_data,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_sof,
   output logic        out_eof,
   output logic        stat_valid,
   output logic        stat_crc_ok,
   output logic        stat_len_err,
   output logic [10:0] stat_len,
`ifdef GMII_RX_MAC_FILTER_EN
   output logic        stat_drop,
`endif
   output logic [15:0] cnt_good,
   output logic [15:0] cnt_bad
);

   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
   localparam logic [10:0] MIN_L       = MIN_LEN[10:0];
   localparam logic [10:0] MAX_L       = MAX_LEN[10:0];

   typedef enum logic [2:0] {
      S_WAIT,
      S_IDLE,
      S_PRE,
      S_DATA,
      S_DISCARD
   } state_t;

   state_t      state, state_nx;

   logic        d1_dv;
   logic [7:0]  d1_data;

   logic [31:0] crc;
   logic [10:0] len_cnt;
   logic [7:0]  held_data;
   logic        held_valid;
   logic        held_first;

   logic        emit, emit_eof, take, frame_start, pre_err, ovf;
   logic        good_inc, bad_inc;

`ifdef GMII_RX_MAC_FILTER_EN
   logic [47:0] mac_sr;
   logic        mac_local_ok;
   logic        mac_bcast_ok;
`endif

   // One byte of reflected CRC-32, LSB first
   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int unsigned i = 0; i < 8; i++) begin
         if (r[0] ^ b[i])
            r = (r >> 1) ^ CRC_POLY;
         else
            r = r >> 1;
      end
      return r;
   endfunction

   // Input register stage; dv resets to 1 so WAIT only leaves on a genuinely sampled idle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         d1_dv   <= 1'b1;
         d1_data <= '0;
      end else begin
         d1_dv   <= rx_dv;
         d1_data <= rx_data;
      end
   end

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= S_WAIT;
      else
         state <= state_nx;
   end

   // Next-state and per-cycle control decode
   always_comb begin
      state_nx    = state;
      emit        = 1'b0;
      emit_eof    = 1'b0;
      take        = 1'b0;
      frame_start = 1'b0;
      pre_err     = 1'b0;
      ovf         = 1'b0;
      case (state)
         S_WAIT: begin
            if (!d1_dv)
               state_nx = S_IDLE;
         end
         S_IDLE: begin
            if (d1_dv) begin
               if (d1_data == 8'h55) begin
                  state_nx = S_PRE;
               end else begin
                  state_nx = S_WAIT;
                  pre_err  = 1'b1;
               end
            end
         end
         S_PRE: begin
            if (!d1_dv) begin
               state_nx = S_IDLE;
            end else if (d1_data == 8'h55) begin
               state_nx = S_PRE;
            end else if (d1_data == 8'hD5) begin
               state_nx    = S_DATA;
               frame_start = 1'b1;
            end else begin
               state_nx = S_WAIT;
               pre_err  = 1'b1;
            end
         end
         S_DATA: begin
            if (!d1_dv) begin
               state_nx = S_IDLE;
               emit     = held_valid;
               emit_eof = held_valid;
            end else if (len_cnt == MAX_L) begin
               // byte MAX_LEN+1: close out the held byte as an overlength frame
               state_nx = S_DISCARD;
               ovf      = 1'b1;
               emit     = 1'b1;
               emit_eof = 1'b1;
            end else begin
               take = 1'b1;
               emit = held_valid;
            end
         end
         S_DISCARD: begin
            if (!d1_dv)
               state_nx = S_IDLE;
         end
         default: state_nx = S_WAIT;
      endcase
   end

   // Datapath: one-byte hold stage, CRC, length, output and status registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         crc          <= '1;
         len_cnt      <= '0;
         held_data    <= '0;
         held_valid   <= 1'b0;
         held_first   <= 1'b0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_sof      <= 1'b0;
         out_eof      <= 1'b0;
         stat_valid   <= 1'b0;
         stat_crc_ok  <= 1'b0;
         stat_len_err <= 1'b0;
         stat_len     <= '0;
`ifdef GMII_RX_MAC_FILTER_EN
         stat_drop    <= 1'b0;
         mac_sr       <= '0;
         mac_local_ok <= 1'b0;
         mac_bcast_ok <= 1'b0;
`endif
      end else begin
         out_valid  <= emit;
         out_sof    <= emit & held_first;
         out_eof    <= emit_eof;
         stat_valid <= emit_eof;
         if (emit)
            out_data <= held_data;
         if (emit_eof) begin
            held_valid   <= 1'b0;
            stat_len     <= len_cnt;
            stat_len_err <= ovf | (len_cnt < MIN_L);
            stat_crc_ok  <= ~ovf & (crc == CRC_RESIDUE);
`ifdef GMII_RX_MAC_FILTER_EN
            stat_drop    <= ~(mac_local_ok | mac_bcast_ok) | (len_cnt < 11'd6);
`endif
         end
         if (frame_start) begin
            crc        <= '1;
            len_cnt    <= '0;
            held_valid <= 1'b0;
`ifdef GMII_RX_MAC_FILTER_EN
            mac_sr       <= LOCAL_MAC;
            mac_local_ok <= 1'b1;
            mac_bcast_ok <= 1'b1;
`endif
         end
         if (take) begin
            crc        <= crc32_byte(crc, d1_data);
            len_cnt    <= len_cnt + 11'd1;
            held_data  <= d1_data;
            held_valid <= 1'b1;
            held_first <= (len_cnt == 11'd0);
`ifdef GMII_RX_MAC_FILTER_EN
            if (len_cnt < 11'd6) begin
               mac_local_ok <= mac_local_ok & (d1_data == mac_sr[47:40]);
               mac_bcast_ok <= mac_bcast_ok & (d1_data == 8'hFF);
               mac_sr       <= {mac_sr[39:0], 8'h00};
            end
`endif
         end
      end
   end

   // Frame classification for the counters, taken from the status word
   always_comb begin
`ifdef GMII_RX_MAC_FILTER_EN
      good_inc = stat_valid & stat_crc_ok & ~stat_len_err & ~stat_drop;
`else
      good_inc = stat_valid & stat_crc_ok & ~stat_len_err;
`endif
      bad_inc  = stat_valid & ~good_inc;
   end

   // Wrapping frame counters; status completion and preamble error can land on one edge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_good <= '0;
         cnt_bad  <= '0;
      end else begin
         cnt_good <= cnt_good + 16'(good_inc);
         cnt_bad  <= cnt_bad + 16'(bad_inc) + 16'(pre_err);
      end
   end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// tb_gmii_rx_frame: directed self-checking bench for gmii_rx_frame.
module tb_gmii_rx_frame;

   localparam logic [47:0] MAC = 48'h00_12_34_56_78_9A;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx_dv = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        out_valid, out_sof, out_eof;
   logic [7:0]  out_data;
   logic        stat_valid, stat_crc_ok, stat_len_err;
   logic [10:0] stat_len;
   logic [15:0] cnt_good, cnt_bad;
`ifdef GMII_RX_MAC_FILTER_EN
   logic        stat_drop;
`endif

   gmii_rx_frame #(
      .MIN_LEN   (64),
      .MAX_LEN   (1518),
      .LOCAL_MAC (MAC)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .rx_dv        (rx_dv),
      .rx_data      (rx_data),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_sof      (out_sof),
      .out_eof      (out_eof),
      .stat_valid   (stat_valid),
      .stat_crc_ok  (stat_crc_ok),
      .stat_len_err (stat_len_err),
      .stat_len     (stat_len),
`ifdef GMII_RX_MAC_FILTER_EN
      .stat_drop    (stat_drop),
`endif
      .cnt_good     (cnt_good),
      .cnt_bad      (cnt_bad)
   );

   always #4 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge
   logic [7:0] rx_buf [0:8191];
   int rx_n = 0, n_sof = 0, n_eof = 0, n_stat = 0;
   int sof_at = -1, eof_at = -1, sof_cyc = 0;
   always @(negedge clock) begin
      if (out_valid) begin
         if (out_sof) begin
            n_sof++;
            sof_at  = rx_n;
            sof_cyc = cyc;
         end
         if (out_eof) begin
            n_eof++;
            eof_at = rx_n;
         end
         if (rx_n < 8192) rx_buf[rx_n] = out_data;
         rx_n++;
      end
      if (stat_valid) n_stat++;
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   logic [7:0] frame_buf [0:2047];
   int first_cyc = 0;

   // Fill frame_buf: dest address, pattern payload, optional FCS (LSB first)
   task automatic build_frame(input int total, input logic [47:0] dest, input bit fcs);
      logic [31:0] c;
      logic [7:0]  b;
      int plen;
      c = '1;
      plen = fcs ? total - 4 : total;
      for (int i = 0; i < plen; i++) begin
         b = (i < 6) ? dest[47 - 8*i -: 8] : 8'(i * 13 + 5);
         frame_buf[i] = b;
         c = ref_crc(c, b);
      end
      if (fcs) begin
         c = ~c;
         for (int k = 0; k < 4; k++) frame_buf[plen + k] = c[8*k +: 8];
      end
   endtask

   task automatic drive(input logic dv, input logic [7:0] d);
      @(negedge clock);
      rx_dv   = dv;
      rx_data = d;
   endtask

   task automatic send_frame(input int len, input int idle);
      for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
      drive(1'b1, 8'hD5);
      for (int i = 0; i < len; i++) begin
         drive(1'b1, frame_buf[i]);
         if (i == 0) first_cyc = cyc + 1;
      end
      for (int i = 0; i < idle; i++) drive(1'b0, 8'h00);
   endtask

   int base_rx, base_sof, base_eof, base_stat, derr;

   task automatic mark();
      base_rx   = rx_n;
      base_sof  = n_sof;
      base_eof  = n_eof;
      base_stat = n_stat;
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clock);
      check("rst_out_valid", out_valid, 0);
      check("rst_stat_valid", stat_valid, 0);
      check("rst_stat_len", stat_len, 0);
      check("rst_cnt_good", cnt_good, 0);
      check("rst_cnt_bad", cnt_bad, 0);
      reset_n = 1'b1;
      repeat (3) drive(1'b0, 8'h00);

      // good 64-byte frame
      build_frame(64, MAC, 1'b1);
      mark();
      send_frame(64, 12);
      check("good_nbytes", rx_n - base_rx, 64);
      check("good_sof_pos", sof_at, base_rx);
      check("good_eof_pos", eof_at, base_rx + 63);
      check("good_latency", sof_cyc - first_cyc, 2);
      derr = 0;
      for (int i = 0; i < 64; i++) if (rx_buf[base_rx + i] !== frame_buf[i]) derr++;
      check("good_data", derr, 0);
      check("good_nstat", n_stat - base_stat, 1);
      check("good_crc_ok", stat_crc_ok, 1);
      check("good_len_err", stat_len_err, 0);
      check("good_len", stat_len, 64);
      check("good_cnt_good", cnt_good, 1);
      check("good_cnt_bad", cnt_bad, 0);
`ifdef GMII_RX_MAC_FILTER_EN
      check("good_drop", stat_drop, 0);
`endif

      // payload byte 10 corrupted
      build_frame(64, MAC, 1'b1);
      frame_buf[9] = frame_buf[9] ^ 8'h01;
      send_frame(64, 12);
      check("corrupt_crc_ok", stat_crc_ok, 0);
      check("corrupt_len", stat_len, 64);
      check("corrupt_cnt_bad", cnt_bad, 1);
      check("corrupt_cnt_good", cnt_good, 1);

      // 40-byte runt with valid FCS
      build_frame(40, MAC, 1'b1);
      send_frame(40, 12);
      check("runt_len_err", stat_len_err, 1);
      check("runt_len", stat_len, 40);
      check("runt_crc_ok", stat_crc_ok, 1);
      check("runt_cnt_bad", cnt_bad, 2);

      // 1600-byte overlength frame
      build_frame(1600, MAC, 1'b1);
      mark();
      send_frame(1600, 12);
      check("ovl_nbytes", rx_n - base_rx, 1518);
      check("ovl_eof_pos", eof_at, base_rx + 1517);
      check("ovl_neof", n_eof - base_eof, 1);
      check("ovl_nstat", n_stat - base_stat, 1);
      check("ovl_len", stat_len, 1518);
      check("ovl_len_err", stat_len_err, 1);
      check("ovl_crc_ok", stat_crc_ok, 0);
      derr = 0;
      for (int i = 0; i < 1518; i++) if (rx_buf[base_rx + i] !== frame_buf[i]) derr++;
      check("ovl_data", derr, 0);
      check("ovl_cnt_bad", cnt_bad, 3);

      // next frame after overlength
      build_frame(64, MAC, 1'b1);
      send_frame(64, 12);
      check("post_ovl_crc_ok", stat_crc_ok, 1);
      check("post_ovl_len", stat_len, 64);
      check("post_ovl_cnt_good", cnt_good, 2);

      // preamble 55 55 57
      mark();
      drive(1'b1, 8'h55);
      drive(1'b1, 8'h55);
      drive(1'b1, 8'h57);
      repeat (8) drive(1'b0, 8'h00);
      check("pre_err_nbytes", rx_n - base_rx, 0);
      check("pre_err_cnt_bad", cnt_bad, 4);

      // dv dropped after 3x55
      mark();
      repeat (3) drive(1'b1, 8'h55);
      repeat (8) drive(1'b0, 8'h00);
      check("pre_drop_nbytes", rx_n - base_rx, 0);
      check("pre_drop_cnt_bad", cnt_bad, 4);

      // SFD then immediately idle
      mark();
      send_frame(0, 12);
      check("empty_nbytes", rx_n - base_rx, 0);
      check("empty_nstat", n_stat - base_stat, 0);
      check("empty_cnt_bad", cnt_bad, 4);
      check("empty_cnt_good", cnt_good, 2);

      // single-byte frame
      frame_buf[0] = 8'hA7;
      mark();
      send_frame(1, 12);
      check("one_nbytes", rx_n - base_rx, 1);
      check("one_sof_pos", sof_at, base_rx);
      check("one_eof_pos", eof_at, base_rx);
      check("one_data", rx_buf[base_rx], 8'hA7);
      check("one_len", stat_len, 1);
      check("one_len_err", stat_len_err, 1);
      check("one_cnt_bad", cnt_bad, 5);

      // back-to-back with one idle cycle
      build_frame(64, MAC, 1'b1);
      mark();
      send_frame(64, 1);
      send_frame(64, 12);
      check("b2b_nbytes", rx_n - base_rx, 128);
      check("b2b_nsof", n_sof - base_sof, 2);
      check("b2b_neof", n_eof - base_eof, 2);
      check("b2b_nstat", n_stat - base_stat, 2);
      check("b2b_crc_ok", stat_crc_ok, 1);
      check("b2b_cnt_good", cnt_good, 4);
      check("b2b_cnt_bad", cnt_bad, 5);

      // reset asserted mid-frame, released with dv still high
      build_frame(64, MAC, 1'b1);
      for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
      drive(1'b1, 8'hD5);
      for (int i = 0; i < 20; i++) drive(1'b1, frame_buf[i]);
      check("mid_pre_valid", out_valid, 1);
      #1 reset_n = 1'b0;
      #1;
      check("mid_async_valid", out_valid, 0);
      check("mid_async_cnt_good", cnt_good, 0);
      check("mid_async_cnt_bad", cnt_bad, 0);
      mark();
      drive(1'b1, frame_buf[20]);
      drive(1'b1, frame_buf[21]);
      reset_n = 1'b1;
      for (int i = 22; i < 64; i++) drive(1'b1, frame_buf[i]);
      repeat (12) drive(1'b0, 8'h00);
      check("mid_nbytes", rx_n - base_rx, 0);
      check("mid_nstat", n_stat - base_stat, 0);
      check("mid_cnt_bad", cnt_bad, 0);
      mark();
      send_frame(64, 12);
      check("mid_next_nbytes", rx_n - base_rx, 64);
      check("mid_next_crc_ok", stat_crc_ok, 1);
      check("mid_next_cnt_good", cnt_good, 1);

`ifdef GMII_RX_MAC_FILTER_EN
      // broadcast destination accepted
      build_frame(64, 48'hFFFF_FFFF_FFFF, 1'b1);
      send_frame(64, 12);
      check("bcast_drop", stat_drop, 0);
      check("bcast_crc_ok", stat_crc_ok, 1);
      check("bcast_cnt_good", cnt_good, 2);

      // foreign destination dropped but still delivered
      build_frame(64, 48'h0200_0000_0001, 1'b1);
      mark();
      send_frame(64, 12);
      check("foreign_nbytes", rx_n - base_rx, 64);
      check("foreign_drop", stat_drop, 1);
      check("foreign_cnt_bad", cnt_bad, 1);
      check("foreign_cnt_good", cnt_good, 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/gmii_rx_frame.md
# gmii_rx_frame

Receive framer between the PHY GMII receive pins and the packet buffer/LED display logic. It strips the preamble and SFD, checks the frame check sequence, and enforces length limits. It delivers the frame as a byte stream with start and end markers, plus a one-cycle status word at end of frame. At top level `clock` is driven from `phy1_rx_clk`.

## Interface
- `MIN_LEN`, 64: minimum legal frame length in bytes, from destination MAC to FCS inclusive.
- `MAX_LEN`, 1518: maximum legal frame length in bytes; must be ≤ 2047.
- `LOCAL_MAC`, 48'h00_12_34_56_78_9A: station address, used only when the filter is compiled in.
- `clock` in 1: receive clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_dv` in 1: GMII receive data valid.
- `rx_data` in 8: GMII receive byte.
- `out_valid` out 1: `out_data` carries a frame byte this cycle.
- `out_data` out 8: frame byte, FCS included.
- `out_sof` out 1: first byte of frame, qualified by `out_valid`.
- `out_eof` out 1: last byte of frame, qualified by `out_valid`.
- `stat_valid` out 1: one-cycle pulse, coincident with `out_eof`.
- `stat_crc_ok` out 1: FCS residue correct.
- `stat_len_err` out 1: length < `MIN_LEN` or > `MAX_LEN`.
- `stat_len` out 11: bytes delivered in the frame.
- `cnt_good` out 16: frames with `crc_ok`=1 and `len_err`=0 (and not dropped); wraps.
- `cnt_bad` out 16: all other completed frames, plus preamble errors; wraps.

## Operation
- **Reset values.** Every output is 0. The state machine is in WAIT, and the CRC register is 32'hFFFFFFFF.
- **Input stage.** `rx_dv`/`rx_data` are registered once (d1) before the state machine sees them.
- **States.**
  - WAIT: leave for IDLE when d1 dv=0. This is the reset state, so reset released mid-frame never syncs onto frame data.
  - IDLE: dv=1 with byte 0x55 → PRE. dv=1 with any other byte → WAIT, `cnt_bad`+1.
  - PRE: byte 0x55 → stay. Byte 0xD5 → DATA, with the CRC register loaded 32'hFFFFFFFF and the length counter cleared. Any other byte → WAIT, `cnt_bad`+1. dv=0 → IDLE, no count.
  - DATA: each byte updates the CRC and increments the length counter; bytes are emitted per the Timing section. dv=0 → IDLE. If byte `MAX_LEN`+1 arrives → DISCARD.
  - DISCARD: dv=0 → IDLE. Nothing is emitted.
- **CRC.** CRC-32, reflected polynomial 32'hEDB88320, LSB first, one byte per cycle. It covers every DATA byte including the FCS. `stat_crc_ok`=1 iff the register equals 32'hDEBB20E3 after the last byte.
- **Length.** The 11-bit counter counts delivered bytes and never exceeds `MAX_LEN`.
- **Overlength.** When byte `MAX_LEN`+1 arrives, the held byte `MAX_LEN` is emitted with `out_eof`=1, `stat_len_err`=1, `stat_crc_ok`=0 and `stat_len`=`MAX_LEN`, and `cnt_bad`+1.
- **Empty frame.** SFD immediately followed by dv=0 produces no output and no count.
- **Single-byte frame.** `out_sof` and `out_eof` are both 1 on the same byte.
- **Inter-frame gap.** One cycle of dv=0 between frames is sufficient. The next frame is handled normally, with no lost status.
- **Counters.** Both counters wrap from 16'hFFFF to 0. They update on the clock after `stat_valid`.

## Timing
- A DATA byte on the pins at edge N appears on `out_data` at edge N+2. Bytes are emitted one cycle late so that `out_eof` can be decided from the following dv.
- `out_sof` and `out_valid` rise 2 cycles after the first byte following the SFD is on the pins.
- `out_eof`, `stat_valid`, `stat_len`, `stat_crc_ok` and `stat_len_err` are valid in the same cycle as the last byte.
- The `stat_*` fields hold their values until the next `stat_valid`. `stat_valid` is a single-cycle pulse.
- There is no backpressure; the consumer must accept one byte per clock.
- Asserting `reset_n` mid-frame clears all outputs immediately (asynchronously); no partial status is emitted.

## Configuration
- `GMII_RX_MAC_FILTER_EN` defined:
  - Bytes 1–6 are compared against `LOCAL_MAC` and against broadcast 48'hFFFFFFFFFFFF.
  - Adds output `stat_drop` (1 bit, reset 0), valid with `stat_valid`. It is 1 on a mismatch; such a frame counts in `cnt_bad`, not `cnt_good`.
  - The byte stream is still delivered.
  - Frames shorter than 6 bytes have `stat_drop`=1.
- Not defined: there is no `stat_drop` port and no comparator logic.

## Test plan
- **Good frame.** Reset, then 7×0x55, 0xD5, a 60-byte payload and a correct 4-byte FCS → 64 bytes out with latency 2, sof on byte 1, eof on byte 64. Status: `stat_valid`=1, `crc_ok`=1, `len_err`=0, `len`=64; `cnt_good`=1.
- **Corrupted byte.** Same frame with payload byte 10 XOR 0x01 → `crc_ok`=0, `cnt_bad`=1.
- **Runt and overlength.**
  - 40-byte frame with valid FCS → `len_err`=1, `len`=40.
  - 1600-byte frame → eof on byte 1518, `len`=1518, `len_err`=1, no bytes after it, next frame received normally.
- **Preamble errors.** Preamble 0x55,0x55,0x57 → no output, `cnt_bad`+1. dv dropped after 3×0x55 → no output, no count.
- **Back-to-back.** Two good 64-byte frames with one idle cycle between → two sof/eof pairs, two `stat_valid` pulses, `cnt_good`=2.
- **Reset and filter.**
  - Reset asserted mid-frame and released with dv still high → no output until dv=0 then a new frame.
  - With `GMII_RX_MAC_FILTER_EN`: dest FF:FF:FF:FF:FF:FF gives `stat_drop`=0; dest 02:00:00:00:00:01 gives `stat_drop`=1 and `cnt_bad`+1.
